// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: mode encoding, counter width and
// default field limits, plus the binary-to-BCD split used by the core.
package stopwatch_pkg;

    localparam int CNT_W       = 6;
    localparam int MAX_MIN_DEF = 59;
    localparam int MAX_SEC_DEF = 59;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSE   = 2'd1,
        ADJ_MIN = 2'd2,
        ADJ_SEC = 2'd3
    } sw_state_e;

    // Returns {tens, ones} as two BCD nibbles for a 0..63 binary value.
    function automatic logic [7:0] to_bcd(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] tens_v;
        logic [CNT_W-1:0] ones_v;
        tens_v = v / 6'd10;
        ones_v = v % 6'd10;
        return {tens_v[3:0], ones_v[3:0]};
    endfunction

endpackage

// File: rtl/stopwatch_mod_counter.sv
// Modulo-(MAX+1) enable counter used for both the seconds and minutes fields.
// wrap flags the enabled cycle on which the field rolls back to zero.
module mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = MAX_SEC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] value,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

    logic [CNT_W-1:0] value_r;

    // Roll-over flag: only meaningful on an enabled cycle at the top value.
    always_comb begin
        wrap = en & (value_r == MAX_V);
    end

    // Field register; reset wins over any enable in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (wrap) begin
                value_r <= {CNT_W{1'b0}};
            end else begin
                value_r <= value_r + 6'd1;
            end
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch MM:SS core: mode FSM driven by debounced levels, two modulo
// counters, blink phase, and BCD/blank outputs for the display driver.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = MAX_MIN_DEF,
    parameter int MAX_SEC = MAX_SEC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_blink,
    input  logic       validPueBtn,
    input  logic       validSel,
    input  logic       validAdj,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       blank_min,
    output logic       blank_sec,
    output logic [1:0] mode
);

    sw_state_e        state_r;
    sw_state_e        next_state_s;
    logic             blink_phase_r;
    logic             sec_en_s;
    logic             min_en_s;
    logic             sec_wrap_s;
    logic             min_wrap_unused_s;
    logic [CNT_W-1:0] sec_val_s;
    logic [CNT_W-1:0] min_val_s;
    logic [7:0]       min_bcd_s;
    logic [7:0]       sec_bcd_s;

    // Mode register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next mode from the debounced levels; adjust outranks pause.
    always_comb begin
        next_state_s = RUN;
        if (validAdj) begin
            if (validSel) begin
                next_state_s = ADJ_SEC;
            end else begin
                next_state_s = ADJ_MIN;
            end
        end else if (validPueBtn) begin
            next_state_s = PAUSE;
        end else begin
            next_state_s = RUN;
        end
    end

    // Per-field increment enables, chosen by the registered mode only.
    always_comb begin
        sec_en_s = 1'b0;
        min_en_s = 1'b0;
        case (state_r)
            RUN: begin
                sec_en_s = tick_1hz;
                min_en_s = sec_wrap_s;
            end
            PAUSE: begin
                sec_en_s = 1'b0;
                min_en_s = 1'b0;
            end
            ADJ_MIN: begin
                sec_en_s = 1'b0;
                min_en_s = tick_2hz;
            end
            ADJ_SEC: begin
                sec_en_s = tick_2hz;
                min_en_s = 1'b0;
            end
            default: begin
                sec_en_s = 1'b0;
                min_en_s = 1'b0;
            end
        endcase
    end

    mod_counter #(.MAX(MAX_SEC)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .en    (sec_en_s),
        .value (sec_val_s),
        .wrap  (sec_wrap_s)
    );

    mod_counter #(.MAX(MAX_MIN)) u_min (
        .clk   (clk),
        .rst   (rst),
        .en    (min_en_s),
        .value (min_val_s),
        .wrap  (min_wrap_unused_s)
    );

    // Blink phase runs in every mode so entering adjust picks up the live phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_phase_r <= 1'b0;
        end else if (tick_blink) begin
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_phase_r <= blink_phase_r;
        end
    end

    // Display outputs decoded straight from registers, no added latency.
    always_comb begin
        min_bcd_s = to_bcd(min_val_s);
        sec_bcd_s = to_bcd(sec_val_s);
        min_tens  = min_bcd_s[7:4];
        min_ones  = min_bcd_s[3:0];
        sec_tens  = sec_bcd_s[7:4];
        sec_ones  = sec_bcd_s[3:0];
        blank_min = (state_r == ADJ_MIN) & blink_phase_r;
        blank_sec = (state_r == ADJ_SEC) & blink_phase_r;
        mode      = state_r;
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomised self-checking bench for stopwatch_core against a seconds-count
// reference model kept in plain integer arithmetic.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       tick_blink = 1'b0;
    logic       validPueBtn = 1'b0;
    logic       validSel = 1'b0;
    logic       validAdj = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       blank_min, blank_sec;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    // reference model: mode number, minutes, seconds, blink phase
    int m_state = 0;
    int m_min = 0;
    int m_sec = 0;
    bit m_ph = 1'b0;

    stopwatch_core dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .tick_blink(tick_blink), .validPueBtn(validPueBtn), .validSel(validSel),
        .validAdj(validAdj), .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .blank_min(blank_min),
        .blank_sec(blank_sec), .mode(mode)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_digits();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    function automatic logic [3:0] exp_flags();
        return {(m_state == 2) && m_ph, (m_state == 3) && m_ph, 2'(m_state)};
    endfunction

    function automatic logic [15:0] act_digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [3:0] act_flags();
        return {blank_min, blank_sec, mode};
    endfunction

    // One clock: drive ticks at negedge, advance model at posedge, return 1 after.
    task automatic cycle(input bit r, input bit t1, input bit t2, input bit tb);
        int total;
        @(negedge clk);
        rst = r; tick_1hz = t1; tick_2hz = t2; tick_blink = tb;
        @(posedge clk);
        if (r) begin
            m_state = 0; m_min = 0; m_sec = 0; m_ph = 1'b0;
        end else begin
            if (m_state == 0 && t1) begin
                total = (m_min * 60 + m_sec + 1) % 3600;
                m_min = total / 60;
                m_sec = total % 60;
            end else if (m_state == 2 && t2) begin
                m_min = (m_min + 1) % 60;
            end else if (m_state == 3 && t2) begin
                m_sec = (m_sec + 1) % 60;
            end
            if (tb) m_ph = ~m_ph;
            m_state = validAdj ? (validSel ? 3 : 2) : (validPueBtn ? 1 : 0);
        end
        #1;
        rst = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0; tick_blink = 1'b0;
    endtask

    task automatic set_levels(input bit pue, input bit sel, input bit adj);
        validPueBtn = pue; validSel = sel; validAdj = adj;
    endtask

    task automatic test_reset();
        set_levels(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (act_digits() !== 16'h0000) begin
            errors++; $display("FAIL reset_digits got %h want %h", act_digits(), 16'h0000);
        end
        checks++;
        if (act_flags() !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want %b", act_flags(), 4'b0000);
        end
    endtask

    task automatic test_run_count();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 61; i++) begin
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (act_digits() !== exp_digits()) begin
                errors++; $display("FAIL run_step%0d got %h want %h", i, act_digits(), exp_digits());
            end
        end
        checks++;
        if (act_digits() !== 16'h0101) begin
            errors++; $display("FAIL run_61 got %h want %h", act_digits(), 16'h0101);
        end
        checks++;
        if (act_flags() !== 4'b0000) begin
            errors++; $display("FAIL run_flags got %b want %b", act_flags(), 4'b0000);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        set_levels(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70 && m_min != 59; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        set_levels(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70 && m_sec != 59; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        set_levels(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (act_digits() !== 16'h5959) begin
            errors++; $display("FAIL preload got %h want %h", act_digits(), 16'h5959);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (act_digits() !== 16'h0000) begin
            errors++; $display("FAIL wrap_5959 got %h want %h", act_digits(), 16'h0000);
        end
    endtask

    task automatic test_pause();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        set_levels(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        checks++;
        if (act_digits() !== 16'h0005) begin
            errors++; $display("FAIL pause_hold got %h want %h", act_digits(), 16'h0005);
        end
        checks++;
        if (mode !== 2'd1) begin
            errors++; $display("FAIL pause_mode got %0d want %0d", mode, 1);
        end
        set_levels(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (act_digits() !== 16'h0006) begin
            errors++; $display("FAIL pause_resume got %h want %h", act_digits(), 16'h0006);
        end
    endtask

    task automatic test_adj_sec();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 58; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        set_levels(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
            cycle(1'b0, 1'(i == 1), 1'b1, 1'($urandom_range(0, 1)));
            checks++;
            if (act_flags() !== exp_flags()) begin
                errors++; $display("FAIL adjsec_blink%0d got %b want %b", i, act_flags(), exp_flags());
            end
        end
        checks++;
        if (act_digits() !== 16'h0001) begin
            errors++; $display("FAIL adjsec_wrap got %h want %h", act_digits(), 16'h0001);
        end
        checks++;
        if (blank_min !== 1'b0) begin
            errors++; $display("FAIL adjsec_blank_min got %b want %b", blank_min, 1'b0);
        end
    endtask

    task automatic test_adj_override();
        set_levels(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (mode !== 2'd2) begin
            errors++; $display("FAIL override_mode got %0d want %0d", mode, 2);
        end
        for (int i = 0; i < 70 && m_min != 59; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (min_tens !== 4'd0 || min_ones !== 4'd0) begin
            errors++; $display("FAIL override_minwrap got %0d%0d want 00", min_tens, min_ones);
        end
        set_levels(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (mode !== 2'd1) begin
            errors++; $display("FAIL override_exit got %0d want %0d", mode, 1);
        end
    endtask

    task automatic test_reset_mid_adj();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        set_levels(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        set_levels(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 34; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        set_levels(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (act_digits() !== 16'h1234) begin
            errors++; $display("FAIL preload_1234 got %h want %h", act_digits(), 16'h1234);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (act_digits() !== 16'h0000 || act_flags() !== 4'b0000) begin
            errors++; $display("FAIL rst_in_adj got %h/%b want 0000/0000", act_digits(), act_flags());
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (mode !== 2'd2) begin
            errors++; $display("FAIL rst_reenter got %0d want %0d", mode, 2);
        end
    endtask

    task automatic test_random();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) validPueBtn = ~validPueBtn;
            if ($urandom_range(0, 15) == 0) validSel = ~validSel;
            if ($urandom_range(0, 23) == 0) validAdj = ~validAdj;
            cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
            checks++;
            if (act_digits() !== exp_digits() || act_flags() !== exp_flags()) begin
                errors++;
                $display("FAIL random%0d got %h/%b want %h/%b", i, act_digits(), act_flags(),
                         exp_digits(), exp_flags());
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_count();
        test_wrap();
        test_pause();
        test_adj_sec();
        test_adj_override();
        test_reset_mid_adj();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
